core_pip_id: RTL and testbench
==============================

Name: core_pip_id

Overview:
- Instruction Decode stage of the KayRV32 5-stage pipeline. It sits directly downstream of the Instruction Fetch stage and consumes its instruction word, instruction-valid flag and PC.
- Decodes RV32I, reads the register file through combinational read ports, generates immediates and detects load-use hazards.
- Registers a decoded control/data bundle for the Execute stage with 1-cycle latency.

Parameters:
- XLEN, 32, datapath and PC width.
- REG_ADDR_W, 5, register address width.

Ports:
- i_Clk  in  1  clock
- i_Rstn  in  1  reset
- i_StallEn  in  1  hold the ID/EX register (downstream stall)
- i_FlushEn  in  1  replace the ID/EX contents with a bubble
- i_InstrValid  in  1  IF output is a valid instruction
- i_InstrData  in  32  instruction from IF
- i_PC  in  XLEN  PC of i_InstrData
- o_Rs1Addr  out  5  register-file read address 1 (combinational)
- o_Rs2Addr  out  5  register-file read address 2 (combinational)
- i_Rs1Data  in  XLEN  register-file data 1, same cycle
- i_Rs2Data  in  XLEN  register-file data 2, same cycle
- i_ExRdAddr  in  5  destination register of the instruction currently in EX
- i_ExMemRead  in  1  instruction in EX is a load
- o_HazardStall  out  1  load-use stall request to IF (combinational)
- o_Valid  out  1  ID/EX bundle valid
- o_PC  out  XLEN  PC of the decoded instruction
- o_Rs1Val, o_Rs2Val  out  XLEN  operand values
- o_Rs1Addr_q, o_Rs2Addr_q  out  5  registered source addresses, for forwarding
- o_RdAddr  out  5  destination register
- o_Imm  out  XLEN  sign-extended immediate
- o_AluOp  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- o_AluSrcImm  out  1  ALU operand B = immediate
- o_AluSrcPC  out  1  ALU operand A = PC (AUIPC, JAL)
- o_MemRead, o_MemWrite  out  1  load / store
- o_MemFunct  out  3  funct3, carried through for memory size and sign
- o_RegWrite  out  1  writes rd (forced to 0 when rd = x0)
- o_Branch  out  1  conditional branch; funct3 is on o_MemFunct
- o_Jump  out  2  0 none, 1 JAL, 2 JALR
- o_Event  out  1  illegal-instruction pulse

Behaviour:
- Reset is synchronous and active-low: i_Rstn is sampled on the rising edge of i_Clk; 0 resets. Every registered output resets to 0, including o_Valid = 0 and o_Event = 0.
- o_Rs1Addr and o_Rs2Addr are taken from i_InstrData[19:15] and [24:20] unconditionally, combinationally.
- Source usage:
  - rs1 used for every opcode except LUI, AUIPC and JAL.
  - rs2 used for R-type, store and branch.
- o_HazardStall = i_InstrValid & i_ExMemRead & (i_ExRdAddr != 0) & ((rs1 used & rs1 == i_ExRdAddr) | (rs2 used & rs2 == i_ExRdAddr)).
- Immediate formats, all sign-extended from bit 31:
  - I: [31:20]
  - S: {[31:25], [11:7]}
  - B: {[31], [7], [30:25], [11:8], 0}
  - U: {[31:12], 12'b0}
  - J: {[31], [19:12], [20], [30:21], 0}
- Opcode decode:
  - OP: AluOp from funct3 and funct7[5]; funct7[5] selects SUB/SRA.
  - OP-IMM: same as OP, except funct7[5] is only honoured for SRAI.
  - LOAD, STORE: ADD with immediate.
  - BRANCH: SUB.
  - LUI: PASSB with immediate.
  - AUIPC: ADD with PC and immediate.
  - JAL: ADD with PC and immediate.
  - JALR: ADD with rs1 and immediate.
- Illegal instruction: any other opcode, or i_InstrData[1:0] != 2'b11. Response: one-cycle o_Event = 1 and a bubble is registered. The instruction must be valid for o_Event to fire.
- Register update priority, highest first:
  1. Reset.
  2. Flush: bubble, with o_Valid = 0 and all control bits = 0. Data fields are don't-care.
  3. i_StallEn: all outputs hold. o_Event is cleared to 0.
  4. o_HazardStall: bubble registered. IF holds its instruction, so it is re-decoded next cycle.
  5. i_InstrValid = 0: bubble.
  6. Otherwise: decoded bundle registered, o_Valid = 1.
- Simultaneous flush and hazard: the flush wins. o_HazardStall is still driven combinationally; IF ignores it while flushing.
- Latency: instruction present at edge N appears on the outputs after edge N.

Test Plan:
- Reset check: hold i_Rstn = 0 for 2 cycles -> all outputs 0. Release, present i_InstrValid = 1, 0x00510093 (ADDI x1,x2,5), PC 0x100 -> next cycle o_Valid = 1, o_RdAddr = 1, o_Imm = 5, o_AluOp = 0, o_AluSrcImm = 1, o_RegWrite = 1, o_PC = 0x100.
- Load-use: i_ExMemRead = 1, i_ExRdAddr = 5, instruction 0x00728333 (ADD x6,x5,x7) -> o_HazardStall = 1 the same cycle and a bubble next cycle. Drop i_ExMemRead -> the instruction registers with o_AluOp = 0, o_Rs1Val = i_Rs1Data.
- BEQ x0,x0,-8 (0xFE000CE3) -> o_Branch = 1, o_Imm = 0xFFFFFFF8, o_AluOp = 1, o_RegWrite = 0, o_HazardStall = 0 even with i_ExMemRead = 1 and i_ExRdAddr = 0.
- LUI 0x12345037 -> o_Imm = 0x12345000, o_AluOp = 10. Then 0xFFFFFFFF -> o_Event = 1 for one cycle, o_Valid = 0.
- i_StallEn = 1 for 3 cycles with a changing i_InstrData -> outputs frozen. Then i_FlushEn and i_StallEn both asserted -> bubble (flush wins).
- ADDI x0,x0,0 (0x00000013) -> o_RegWrite = 0.

Source files
------------

// File: rtl/core_pip_id.sv
// core_pip_id: RV32I instruction decode stage with register-file read,
// immediate generation, load-use hazard detection and a registered ID/EX bundle.
module core_pip_id #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rstn,
  input  logic                  i_StallEn,
  input  logic                  i_FlushEn,
  input  logic                  i_InstrValid,
  input  logic [31:0]           i_InstrData,
  input  logic [XLEN-1:0]       i_PC,
  output logic [REG_ADDR_W-1:0] o_Rs1Addr,
  output logic [REG_ADDR_W-1:0] o_Rs2Addr,
  input  logic [XLEN-1:0]       i_Rs1Data,
  input  logic [XLEN-1:0]       i_Rs2Data,
  input  logic [REG_ADDR_W-1:0] i_ExRdAddr,
  input  logic                  i_ExMemRead,
  output logic                  o_HazardStall,
  output logic                  o_Valid,
  output logic [XLEN-1:0]       o_PC,
  output logic [XLEN-1:0]       o_Rs1Val,
  output logic [XLEN-1:0]       o_Rs2Val,
  output logic [REG_ADDR_W-1:0] o_Rs1Addr_q,
  output logic [REG_ADDR_W-1:0] o_Rs2Addr_q,
  output logic [REG_ADDR_W-1:0] o_RdAddr,
  output logic [XLEN-1:0]       o_Imm,
  output logic [3:0]            o_AluOp,
  output logic                  o_AluSrcImm,
  output logic                  o_AluSrcPC,
  output logic                  o_MemRead,
  output logic                  o_MemWrite,
  output logic [2:0]            o_MemFunct,
  output logic                  o_RegWrite,
  output logic                  o_Branch,
  output logic [1:0]            o_Jump,
  output logic                  o_Event
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       imm;
    logic [3:0]            alu_op;
    logic                  src_imm;
    logic                  src_pc;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_funct;
    logic                  reg_write;
    logic                  branch;
    logic [1:0]            jump;
    logic                  event_p;
  } bundle_t;

  function automatic logic [3:0] alu_f(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_f = ALU_SLL;
      3'd2:    alu_f = ALU_SLT;
      3'd3:    alu_f = ALU_SLTU;
      3'd4:    alu_f = ALU_XOR;
      3'd5:    alu_f = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f = ALU_OR;
      default: alu_f = ALU_AND;
    endcase
  endfunction

  logic [6:0]            opc;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  is_op, is_opi, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic                  legal, rs1_used, rs2_used, hazard;
  logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t               dec, held, bad, bundle_d, bundle_q;

  assign opc      = i_InstrData[6:0];
  assign funct3   = i_InstrData[14:12];
  assign rs1      = i_InstrData[19:15];
  assign rs2      = i_InstrData[24:20];
  assign rd       = i_InstrData[11:7];
  assign is_op    = opc == OPC_OP;
  assign is_opi   = opc == OPC_OPIMM;
  assign is_ld    = opc == OPC_LOAD;
  assign is_st    = opc == OPC_STORE;
  assign is_br    = opc == OPC_BRANCH;
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign legal    = is_op | is_opi | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;
  assign rs1_used = ~(is_lui | is_auipc | is_jal);
  assign rs2_used = is_op | is_st | is_br;

  assign o_Rs1Addr     = rs1;
  assign o_Rs2Addr     = rs2;
  assign hazard        = i_InstrValid & i_ExMemRead & (i_ExRdAddr != '0) &
                         ((rs1_used & (rs1 == i_ExRdAddr)) | (rs2_used & (rs2 == i_ExRdAddr)));
  assign o_HazardStall = hazard;

  assign imm_i = XLEN'($signed(i_InstrData[31:20]));
  assign imm_s = XLEN'($signed({i_InstrData[31:25], i_InstrData[11:7]}));
  assign imm_b = XLEN'($signed({i_InstrData[31], i_InstrData[7], i_InstrData[30:25], i_InstrData[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i_InstrData[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i_InstrData[31], i_InstrData[19:12], i_InstrData[20], i_InstrData[30:21], 1'b0}));

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.pc        = i_PC;
    dec.rs1_val   = i_Rs1Data;
    dec.rs2_val   = i_Rs2Data;
    dec.rs1_addr  = rs1;
    dec.rs2_addr  = rs2;
    dec.rd_addr   = rd;
    dec.imm       = is_st ? imm_s : is_br ? imm_b : (is_lui | is_auipc) ? imm_u :
                    is_jal ? imm_j : is_op ? '0 : imm_i;
    // only shifts-right look at funct7[5] for immediates; ADDI must not become SUB
    dec.alu_op    = is_op  ? alu_f(funct3, i_InstrData[30]) :
                    is_opi ? alu_f(funct3, i_InstrData[30] & (funct3 == 3'd5)) :
                    is_br  ? ALU_SUB : is_lui ? ALU_PASSB : ALU_ADD;
    dec.src_imm   = ~(is_op | is_br);
    dec.src_pc    = is_auipc | is_jal;
    dec.mem_read  = is_ld;
    dec.mem_write = is_st;
    dec.mem_funct = funct3;
    dec.reg_write = (is_op | is_opi | is_ld | is_lui | is_auipc | is_jal | is_jalr) & (rd != '0);
    dec.branch    = is_br;
    dec.jump      = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
    held          = bundle_q;
    held.event_p  = 1'b0;
    bad           = '0;
    bad.event_p   = i_InstrValid & ~legal & ~hazard;
    bundle_d      = i_FlushEn ? '0 : i_StallEn ? held :
                    (hazard | ~i_InstrValid | ~legal) ? bad : dec;
  end

  always_ff @(posedge i_Clk)
    if (!i_Rstn) bundle_q <= '0;
    else         bundle_q <= bundle_d;

  assign o_Valid       = bundle_q.valid;
  assign o_PC          = bundle_q.pc;
  assign o_Rs1Val      = bundle_q.rs1_val;
  assign o_Rs2Val      = bundle_q.rs2_val;
  assign o_Rs1Addr_q   = bundle_q.rs1_addr;
  assign o_Rs2Addr_q   = bundle_q.rs2_addr;
  assign o_RdAddr      = bundle_q.rd_addr;
  assign o_Imm         = bundle_q.imm;
  assign o_AluOp       = bundle_q.alu_op;
  assign o_AluSrcImm   = bundle_q.src_imm;
  assign o_AluSrcPC    = bundle_q.src_pc;
  assign o_MemRead     = bundle_q.mem_read;
  assign o_MemWrite    = bundle_q.mem_write;
  assign o_MemFunct    = bundle_q.mem_funct;
  assign o_RegWrite    = bundle_q.reg_write;
  assign o_Branch      = bundle_q.branch;
  assign o_Jump        = bundle_q.jump;
  assign o_Event       = bundle_q.event_p;

endmodule

// File: tb/tb_core_pip_id.sv
// tb_core_pip_id: directed and randomized checks of core_pip_id against a
// behavioural decode model.
module tb_core_pip_id;

  logic        clk, rstn, stall, flush, ivalid, ex_mr;
  logic [31:0] instr, pc, r1d, r2d;
  logic [4:0]  ex_rd;
  logic [4:0]  rs1a, rs2a, rs1q, rs2q, rdq;
  logic        hz, valid, asimm, aspc, mr, mw, rw, br, ev;
  logic [31:0] opc, r1v, r2v, imm;
  logic [3:0]  aluop;
  logic [2:0]  mf;
  logic [1:0]  jmp;

  int checks = 0;
  int failures = 0;

  core_pip_id dut (
    .i_Clk(clk), .i_Rstn(rstn), .i_StallEn(stall), .i_FlushEn(flush),
    .i_InstrValid(ivalid), .i_InstrData(instr), .i_PC(pc),
    .o_Rs1Addr(rs1a), .o_Rs2Addr(rs2a), .i_Rs1Data(r1d), .i_Rs2Data(r2d),
    .i_ExRdAddr(ex_rd), .i_ExMemRead(ex_mr), .o_HazardStall(hz),
    .o_Valid(valid), .o_PC(opc), .o_Rs1Val(r1v), .o_Rs2Val(r2v),
    .o_Rs1Addr_q(rs1q), .o_Rs2Addr_q(rs2q), .o_RdAddr(rdq), .o_Imm(imm),
    .o_AluOp(aluop), .o_AluSrcImm(asimm), .o_AluSrcPC(aspc),
    .o_MemRead(mr), .o_MemWrite(mw), .o_MemFunct(mf), .o_RegWrite(rw),
    .o_Branch(br), .o_Jump(jmp), .o_Event(ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, r1v, r2v;
    logic [4:0]  a1, a2, rd;
    logic [31:0] imm;
    logic        imm_chk;
    logic [3:0]  alu;
    logic        simm, spc, mr, mw;
    logic [2:0]  mf;
    logic        rw, br;
    logic [1:0]  jmp;
    logic        ev, illegal;
  } mdl_t;

  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  localparam logic [6:0] OPS [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                      7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h3B};

  mdl_t m;

  function automatic mdl_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
    mdl_t d;
    logic signed [31:0] s;
    logic [31:0] ii, is, ib, iu, ij;
    logic [2:0] f3;
    logic wr;
    s  = ins;
    f3 = ins[14:12];
    ii = 32'(s >>> 20);
    is = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    ib = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    iu = ins & 32'hFFFF_F000;
    ij = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    d = '0;
    d.imm_chk = 1'b1;
    wr = 1'b0;
    case (ins[6:0])
      7'h33: begin d.alu = ALU_TAB[f3] + 4'(((f3 == 3'd0) || (f3 == 3'd5)) && ins[30]); d.imm_chk = 1'b0; wr = 1'b1; end
      7'h13: begin d.alu = ALU_TAB[f3] + 4'((f3 == 3'd5) && ins[30]); d.simm = 1'b1; d.imm = ii; wr = 1'b1; end
      7'h03: begin d.simm = 1'b1; d.mr = 1'b1; d.imm = ii; wr = 1'b1; end
      7'h23: begin d.simm = 1'b1; d.mw = 1'b1; d.imm = is; end
      7'h63: begin d.alu = 4'd1; d.br = 1'b1; d.imm = ib; end
      7'h37: begin d.alu = 4'd10; d.simm = 1'b1; d.imm = iu; wr = 1'b1; end
      7'h17: begin d.simm = 1'b1; d.spc = 1'b1; d.imm = iu; wr = 1'b1; end
      7'h6F: begin d.simm = 1'b1; d.spc = 1'b1; d.imm = ij; d.jmp = 2'd1; wr = 1'b1; end
      7'h67: begin d.simm = 1'b1; d.imm = ii; d.jmp = 2'd2; wr = 1'b1; end
      default: d.illegal = 1'b1;
    endcase
    d.valid = 1'b1;
    d.pc    = p;
    d.r1v   = a;
    d.r2v   = b;
    d.a1    = ins[19:15];
    d.a2    = ins[24:20];
    d.rd    = ins[11:7];
    d.mf    = f3;
    d.rw    = wr && (ins[11:7] != 5'd0);
    return d;
  endfunction

  function automatic logic ref_hz(input logic [31:0] ins, input logic v,
                                  input logic lm, input logic [4:0] erd);
    logic u1, u2;
    u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
    u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
    return v && lm && (erd != 5'd0) &&
           ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    ivalid = v;
    instr  = ins;
    pc     = p;
    r1d    = $urandom;
    r2d    = $urandom;
  endtask

  task automatic settle();
    #1;
    chk("hazard", 32'(hz), 32'(ref_hz(instr, ivalid, ex_mr, ex_rd)));
    chk("rs1_addr", 32'(rs1a), 32'(instr[19:15]));
    chk("rs2_addr", 32'(rs2a), 32'(instr[24:20]));
  endtask

  task automatic tick();
    mdl_t d;
    if (!rstn || flush) m = '0;
    else if (stall) m.ev = 1'b0;
    else if (ref_hz(instr, ivalid, ex_mr, ex_rd) || !ivalid) m = '0;
    else begin
      d = ref_dec(instr, pc, r1d, r2d);
      if (d.illegal) begin
        m = '0;
        m.ev = 1'b1;
      end else m = d;
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(valid), 32'(m.valid));
    chk("event", 32'(ev), 32'(m.ev));
    chk("alu_op", 32'(aluop), 32'(m.alu));
    chk("src_imm", 32'(asimm), 32'(m.simm));
    chk("src_pc", 32'(aspc), 32'(m.spc));
    chk("mem_read", 32'(mr), 32'(m.mr));
    chk("mem_write", 32'(mw), 32'(m.mw));
    chk("reg_write", 32'(rw), 32'(m.rw));
    chk("branch", 32'(br), 32'(m.br));
    chk("jump", 32'(jmp), 32'(m.jmp));
    if (m.valid) begin
      chk("pc", opc, m.pc);
      chk("rs1_val", r1v, m.r1v);
      chk("rs2_val", r2v, m.r2v);
      chk("rs1_addr_q", 32'(rs1q), 32'(m.a1));
      chk("rs2_addr_q", 32'(rs2q), 32'(m.a2));
      chk("rd_addr", 32'(rdq), 32'(m.rd));
      chk("mem_funct", 32'(mf), 32'(m.mf));
      if (m.imm_chk) chk("imm", imm, m.imm);
    end
  endtask

  initial begin
    logic [31:0] r1_saved, ins;
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
    drive(1'b1, 32'h0051_0093, 32'h100);
    repeat (2) begin settle(); tick(); end
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_event", 32'(ev), 32'd0);
    chk("rst_pc", opc, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_rd", 32'(rdq), 32'd0);
    chk("rst_rs1val", r1v, 32'd0);
    chk("rst_regwrite", 32'(rw), 32'd0);

    rstn = 1'b1;
    drive(1'b1, 32'h0051_0093, 32'h100);
    settle(); tick();
    chk("addi_valid", 32'(valid), 32'd1);
    chk("addi_rd", 32'(rdq), 32'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_alu", 32'(aluop), 32'd0);
    chk("addi_simm", 32'(asimm), 32'd1);
    chk("addi_rw", 32'(rw), 32'd1);
    chk("addi_pc", opc, 32'h100);

    ex_mr = 1'b1; ex_rd = 5'd5;
    drive(1'b1, 32'h0072_8333, 32'h104);
    settle();
    chk("lu_hazard", 32'(hz), 32'd1);
    tick();
    chk("lu_bubble", 32'(valid), 32'd0);
    ex_mr = 1'b0;
    drive(1'b1, 32'h0072_8333, 32'h104);
    r1_saved = r1d;
    settle();
    chk("lu_release_hz", 32'(hz), 32'd0);
    tick();
    chk("lu_valid", 32'(valid), 32'd1);
    chk("lu_alu", 32'(aluop), 32'd0);
    chk("lu_rs1val", r1v, r1_saved);

    ex_mr = 1'b1; ex_rd = 5'd0;
    drive(1'b1, 32'hFE00_0CE3, 32'h108);
    settle();
    chk("beq_hz", 32'(hz), 32'd0);
    tick();
    chk("beq_branch", 32'(br), 32'd1);
    chk("beq_imm", imm, 32'hFFFF_FFF8);
    chk("beq_alu", 32'(aluop), 32'd1);
    chk("beq_rw", 32'(rw), 32'd0);
    ex_mr = 1'b0;

    drive(1'b1, 32'h1234_5037, 32'h10C);
    settle(); tick();
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_alu", 32'(aluop), 32'd10);
    drive(1'b1, 32'hFFFF_FFFF, 32'h110);
    settle(); tick();
    chk("ill_event", 32'(ev), 32'd1);
    chk("ill_valid", 32'(valid), 32'd0);
    drive(1'b1, 32'h0070_0193, 32'h140);
    settle(); tick();
    chk("ill_pulse", 32'(ev), 32'd0);
    chk("addi3_valid", 32'(valid), 32'd1);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0051_0093 + 32'(k << 7), 32'h200 + 32'(k * 4));
      settle(); tick();
      chk("stall_pc", opc, 32'h140);
      chk("stall_rd", 32'(rdq), 32'd3);
      chk("stall_imm", imm, 32'd7);
      chk("stall_valid", 32'(valid), 32'd1);
    end
    flush = 1'b1;
    settle(); tick();
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_rw", 32'(rw), 32'd0);
    stall = 1'b0; flush = 1'b0;

    drive(1'b1, 32'h0000_0013, 32'h300);
    settle(); tick();
    chk("nop_valid", 32'(valid), 32'd1);
    chk("nop_rw", 32'(rw), 32'd0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 11)];
      ex_rd = 5'($urandom_range(0, 3));
      ex_mr = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) ins[19:15] = ex_rd;
      if ($urandom_range(0, 2) == 0) ins[24:20] = ex_rd;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 7) != 0, ins, $urandom & 32'hFFFF_FFFC);
      settle(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
